// File: rtl/seq_gen_moore.sv
// Serial MSB-first pattern transmitter with repeat count; all outputs decoded from registered state.
// Optional inter-repetition idle gap compiled in with SEQ_GEN_GAP_EN.
module seq_gen_moore #(
   parameter int PAT_W   = 4,
   parameter int CNT_W   = 4,
   parameter int GAP_LEN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(PAT_W);

   if (PAT_W < 2 || GAP_LEN < 1) begin : g_bad_params
      $error("seq_gen_moore: PAT_W must be >= 2 and GAP_LEN >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
`ifdef SEQ_GEN_GAP_EN
      S_GAP   = 2'd2,
`endif
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [PAT_W-1:0]  r_shift, w_shift_next;
   logic [PAT_W-1:0]  r_pat, w_pat_next;
   logic [CNT_W-1:0]  r_reps, w_reps_next;
   logic [BW-1:0]     r_bitcnt, w_bitcnt_next;

`ifdef SEQ_GEN_GAP_EN
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   logic [GW-1:0]     r_gapcnt, w_gapcnt_next;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_pat    <= '0;
         r_reps   <= '0;
         r_bitcnt <= '0;
`ifdef SEQ_GEN_GAP_EN
         r_gapcnt <= '0;
`endif
      end else begin
         r_state  <= w_state_next;
         r_shift  <= w_shift_next;
         r_pat    <= w_pat_next;
         r_reps   <= w_reps_next;
         r_bitcnt <= w_bitcnt_next;
`ifdef SEQ_GEN_GAP_EN
         r_gapcnt <= w_gapcnt_next;
`endif
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_shift_next  = r_shift;
      w_pat_next    = r_pat;
      w_reps_next   = r_reps;
      w_bitcnt_next = r_bitcnt;
`ifdef SEQ_GEN_GAP_EN
      w_gapcnt_next = r_gapcnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (reps != '0) begin
                  w_shift_next  = pattern;
                  w_pat_next    = pattern;
                  w_reps_next   = reps;
                  w_bitcnt_next = BW'(PAT_W - 1);
                  w_state_next  = S_SHIFT;
               end else begin
                  w_state_next  = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else begin
               w_shift_next  = r_shift << 1;
               w_bitcnt_next = r_bitcnt - BW'(1);
               if (r_bitcnt == '0) begin
                  if (r_reps == CNT_W'(1)) begin
                     w_state_next = S_DONE;
                  end else begin
                     // Reload from the latched copy so input changes after start are ignored.
                     w_reps_next   = r_reps - CNT_W'(1);
                     w_shift_next  = r_pat;
                     w_bitcnt_next = BW'(PAT_W - 1);
`ifdef SEQ_GEN_GAP_EN
                     w_gapcnt_next = '0;
                     w_state_next  = S_GAP;
`endif
                  end
               end
            end
         end
`ifdef SEQ_GEN_GAP_EN
         S_GAP: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else if (r_gapcnt == GW'(GAP_LEN - 1)) begin
               w_state_next = S_SHIFT;
            end else begin
               w_gapcnt_next = r_gapcnt + GW'(1);
            end
         end
`endif
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      dout       = (r_state == S_SHIFT) && r_shift[PAT_W-1];
      dout_valid = (r_state == S_SHIFT);
      done       = (r_state == S_DONE);
`ifdef SEQ_GEN_GAP_EN
      busy       = (r_state == S_SHIFT) || (r_state == S_GAP) || (r_state == S_DONE);
`else
      busy       = (r_state == S_SHIFT) || (r_state == S_DONE);
`endif
   end

endmodule
